alt_disable: RTL and testbench

ALT_DISABLE -- requirements
Module: alt_disable

---
 rtl/alt_disable_if.sv | 24 ++
 rtl/alt_disable.sv | 108 ++++++++++
 tb/tb_alt_disable.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alt_disable_if.sv
// Memory port bundle for alt_disable: address/mode/write data out, read data in.
interface alt_disable_if #(
    parameter int addrBits = 8,
    parameter int dataBits = 16
) ();
    logic [addrBits-1:0] address;
    logic                readWriteMode;
    logic [dataBits-1:0] dataOut;
    logic [dataBits-1:0] dataIn;

    modport master (
        output address,
        output readWriteMode,
        output dataIn,
        input  dataOut
    );

    modport slave (
        input  address,
        input  readWriteMode,
        input  dataIn,
        output dataOut
    );
endinterface

// File: rtl/alt_disable.sv
// ALT disable: walks a channel list, clears our own stale enables and
// records the first channel that already holds a waiting sender.
module alt_disable #(
    parameter int addrBits = 8,
    parameter int dataBits = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic                finished,
    alt_disable_if.master       ram,
    input  logic [addrBits-1:0] channelList,
    input  logic [addrBits-1:0] channelCount,
    input  logic [addrBits-1:0] rxPid,
    output logic                selected,
    output logic [addrBits-1:0] selectedChannel,
    output logic [addrBits-1:0] selectedIndex
);
    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    typedef enum logic [2:0] {
        INIT,
        FETCH_CHAN,
        CHECK,
        WRITE_0,
        WRITE_1,
        DONE
    } state_t;

    state_t              state;
    state_t              nextState;
    logic [addrBits-1:0] rIdx;
    logic [addrBits-1:0] rChan;
    logic [addrBits-1:0] word;
    logic                clearHit;
    logic                listEnd;

    assign word     = ram.dataOut[addrBits-1:0];
    assign clearHit = (rxPid != '0) && (word == rxPid);
    assign listEnd  = (channelCount == rIdx);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= INIT;
            rIdx            <= '0;
            rChan           <= '0;
            finished        <= 1'b0;
            selected        <= 1'b0;
            selectedChannel <= '0;
            selectedIndex   <= '0;
        end else begin
            state    <= nextState;
            finished <= 1'b0;
            unique case (state)
                INIT: begin
                    if (listEnd)
                        finished <= 1'b1;
                end
                FETCH_CHAN: begin
                    rChan <= word;
                end
                CHECK: begin
                    if (!clearHit) begin
                        rIdx <= rIdx + 1'b1;
                        // Only the lowest-index ready entry is kept.
                        if (word != '0 && !selected) begin
                            selected        <= 1'b1;
                            selectedChannel <= rChan;
                            selectedIndex   <= rIdx;
                        end
                    end
                end
                WRITE_1: begin
                    rIdx <= rIdx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            INIT:       nextState = listEnd ? DONE : FETCH_CHAN;
            FETCH_CHAN: nextState = CHECK;
            CHECK:      nextState = clearHit ? WRITE_0 : INIT;
            WRITE_0:    nextState = WRITE_1;
            WRITE_1:    nextState = INIT;
            DONE:       nextState = DONE;
            default:    nextState = INIT;
        endcase
    end

    always_comb begin
        ram.address       = channelList + rIdx;
        ram.readWriteMode = RAM_READ;
        ram.dataIn        = '0;
        unique case (state)
            FETCH_CHAN: ram.address = word;
            CHECK:      ram.address = rChan;
            WRITE_0, WRITE_1: begin
                ram.address       = rChan;
                ram.readWriteMode = RAM_WRITE;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alt_disable.sv
// Directed bench for alt_disable with a one-cycle-latency RAM model.
module tb_alt_disable;
    localparam logic RAM_WRITE = 1'b1;
    localparam logic RAM_READ  = 1'b0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       finished;
    logic       selected;
    logic [7:0] selectedChannel;
    logic [7:0] selectedIndex;
    logic [7:0] channelList = '0;
    logic [7:0] channelCount = '0;
    logic [7:0] rxPid = '0;

    logic [15:0] mem [256];
    logic        pokeEn = 1'b0;
    logic [7:0]  pokeAddr = '0;
    logic [15:0] pokeData = '0;

    int checks = 0;
    int errors = 0;

    int         nWr;
    logic [7:0] wrAddr [8];
    logic [15:0] wrData [8];
    logic [7:0] addrTrace [64];
    logic       rwTrace [64];
    logic       selTrace [64];
    int         finCyc;
    int         finCount;

    alt_disable_if #(.addrBits(8), .dataBits(16)) ram ();

    alt_disable #(.addrBits(8), .dataBits(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .finished       (finished),
        .ram            (ram),
        .channelList    (channelList),
        .channelCount   (channelCount),
        .rxPid          (rxPid),
        .selected       (selected),
        .selectedChannel(selectedChannel),
        .selectedIndex  (selectedIndex)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pokeEn)
            mem[pokeAddr] <= pokeData;
        else if (ram.readWriteMode == RAM_WRITE)
            mem[ram.address] <= ram.dataIn;
        ram.dataOut <= mem[ram.address];
    end

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        pokeEn   = 1'b1;
        pokeAddr = a;
        pokeData = d;
        @(negedge clk);
        pokeEn = 1'b0;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++)
            poke(i[7:0], 16'h0000);
    endtask

    task automatic run(input logic [7:0] list, input logic [7:0] cnt,
                       input logic [7:0] pid, input int abortAt);
        @(negedge clk);
        reset        = 1'b0;
        channelList  = list;
        channelCount = cnt;
        rxPid        = pid;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        nWr      = 0;
        finCyc   = -1;
        finCount = 0;
        for (int c = 0; c < 64; c++) begin
            addrTrace[c] = ram.address;
            rwTrace[c]   = ram.readWriteMode;
            selTrace[c]  = selected;
            if (ram.readWriteMode == RAM_WRITE && nWr < 8) begin
                wrAddr[nWr] = ram.address;
                wrData[nWr] = ram.dataIn;
                nWr++;
            end
            if (finished) begin
                finCount++;
                if (finCyc < 0) finCyc = c;
            end
            if (c == abortAt) reset = 1'b0;
            if (finCyc >= 0 && c >= finCyc + 4) break;
            if (abortAt >= 0 && c >= abortAt + 4) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (finished !== 1'b0) begin
            errors++;
            $display("FAIL reset_finished got %b want 0", finished);
        end
        checks++;
        if (selected !== 1'b0) begin
            errors++;
            $display("FAIL reset_selected got %b want 0", selected);
        end
        checks++;
        if (selectedChannel !== 8'h00) begin
            errors++;
            $display("FAIL reset_selCh got %h want 00", selectedChannel);
        end
        checks++;
        if (selectedIndex !== 8'h00) begin
            errors++;
            $display("FAIL reset_selIdx got %h want 00", selectedIndex);
        end
        checks++;
        if (ram.readWriteMode !== RAM_READ) begin
            errors++;
            $display("FAIL reset_rw got %b want 0", ram.readWriteMode);
        end
    endtask

    task automatic test_empty();
        run(8'h10, 8'd0, 8'd5, -1);
        checks++;
        if (finCyc != 1) begin
            errors++;
            $display("FAIL empty_fin got %0d want 1", finCyc);
        end
        checks++;
        if (finCount != 1) begin
            errors++;
            $display("FAIL empty_pulse got %0d want 1", finCount);
        end
        checks++;
        if (selected !== 1'b0 || nWr != 0) begin
            errors++;
            $display("FAIL empty_sel got sel %b wr %0d want 0 0", selected, nWr);
        end
    endtask

    task automatic test_clear();
        clearMem();
        poke(8'h10, 16'h0020);
        poke(8'h20, 16'h0005);
        run(8'h10, 8'd1, 8'd5, -1);
        checks++;
        if (nWr != 2) begin
            errors++;
            $display("FAIL clear_nwr got %0d want 2", nWr);
        end
        checks++;
        if (wrAddr[0] !== 8'h20 || wrAddr[1] !== 8'h20 ||
            wrData[0] !== 16'h0 || wrData[1] !== 16'h0) begin
            errors++;
            $display("FAIL clear_wr got %h/%h %h/%h want 20/0000 20/0000",
                     wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
        end
        checks++;
        if (finCyc != 6 || finCount != 1) begin
            errors++;
            $display("FAIL clear_fin got %0d x%0d want 6 x1", finCyc, finCount);
        end
        checks++;
        if (selected !== 1'b0 || mem[8'h20] !== 16'h0) begin
            errors++;
            $display("FAIL clear_state got sel %b mem %h want 0 0000",
                     selected, mem[8'h20]);
        end
    endtask

    task automatic test_select();
        clearMem();
        poke(8'h10, 16'h0020);
        poke(8'h20, 16'h0009);
        run(8'h10, 8'd1, 8'd5, -1);
        checks++;
        if (nWr != 0) begin
            errors++;
            $display("FAIL select_nwr got %0d want 0", nWr);
        end
        checks++;
        if (selected !== 1'b1 || selectedChannel !== 8'h20 ||
            selectedIndex !== 8'h00) begin
            errors++;
            $display("FAIL select_out got %b %h %h want 1 20 00",
                     selected, selectedChannel, selectedIndex);
        end
        checks++;
        if (finCyc != 4) begin
            errors++;
            $display("FAIL select_fin got %0d want 4", finCyc);
        end
    endtask

    task automatic test_three();
        clearMem();
        poke(8'h40, 16'h0020);
        poke(8'h41, 16'h1221);
        poke(8'h42, 16'h0022);
        poke(8'h20, 16'h0005);
        poke(8'h21, 16'hAB07);
        poke(8'h22, 16'h0009);
        run(8'h40, 8'd3, 8'd5, -1);
        checks++;
        if (nWr != 2 || wrAddr[0] !== 8'h20 || wrAddr[1] !== 8'h20) begin
            errors++;
            $display("FAIL three_wr got %0d %h %h want 2 20 20",
                     nWr, wrAddr[0], wrAddr[1]);
        end
        checks++;
        if (selected !== 1'b1 || selectedIndex !== 8'h01 ||
            selectedChannel !== 8'h21) begin
            errors++;
            $display("FAIL three_sel got %b %h %h want 1 01 21",
                     selected, selectedIndex, selectedChannel);
        end
        checks++;
        if (finCyc != 12) begin
            errors++;
            $display("FAIL three_fin got %0d want 12", finCyc);
        end
        checks++;
        if (mem[8'h20] !== 16'h0 || mem[8'h21] !== 16'hAB07 ||
            mem[8'h22] !== 16'h0009) begin
            errors++;
            $display("FAIL three_mem got %h %h %h want 0000 ab07 0009",
                     mem[8'h20], mem[8'h21], mem[8'h22]);
        end
    endtask

    task automatic test_wrap();
        clearMem();
        poke(8'hFE, 16'h0030);
        poke(8'hFF, 16'h0031);
        poke(8'h00, 16'h0032);
        poke(8'h31, 16'h0004);
        poke(8'h32, 16'h0003);
        run(8'hFE, 8'd3, 8'd0, -1);
        checks++;
        if (addrTrace[0] !== 8'hFE || addrTrace[3] !== 8'hFF ||
            addrTrace[6] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_addr got %h %h %h want fe ff 00",
                     addrTrace[0], addrTrace[3], addrTrace[6]);
        end
        checks++;
        if (nWr != 0) begin
            errors++;
            $display("FAIL wrap_nwr got %0d want 0", nWr);
        end
        checks++;
        if (selected !== 1'b1 || selectedIndex !== 8'h01 ||
            selectedChannel !== 8'h31 || finCyc != 10) begin
            errors++;
            $display("FAIL wrap_sel got %b %h %h fin %0d want 1 01 31 10",
                     selected, selectedIndex, selectedChannel, finCyc);
        end
    endtask

    task automatic test_abort();
        clearMem();
        poke(8'h10, 16'h0020);
        poke(8'h11, 16'h0021);
        poke(8'h20, 16'h0009);
        poke(8'h21, 16'h0005);
        run(8'h10, 8'd2, 8'd5, 6);
        checks++;
        if (rwTrace[6] !== RAM_WRITE || selTrace[6] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre got rw %b sel %b want 1 1",
                     rwTrace[6], selTrace[6]);
        end
        checks++;
        if (rwTrace[7] !== RAM_READ || selTrace[7] !== 1'b0 || nWr != 1) begin
            errors++;
            $display("FAIL abort_post got rw %b sel %b nwr %0d want 0 0 1",
                     rwTrace[7], selTrace[7], nWr);
        end
        checks++;
        if (finCyc != -1) begin
            errors++;
            $display("FAIL abort_fin got %0d want -1", finCyc);
        end
        poke(8'h21, 16'h0005);
        run(8'h10, 8'd2, 8'd5, -1);
        checks++;
        if (nWr != 2 || wrAddr[0] !== 8'h21 || finCyc != 9 ||
            selected !== 1'b1 || selectedIndex !== 8'h00 ||
            selectedChannel !== 8'h20) begin
            errors++;
            $display("FAIL abort_rerun got nwr %0d a %h fin %0d sel %b %h %h",
                     nWr, wrAddr[0], finCyc, selected, selectedIndex,
                     selectedChannel);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_clear();
        test_select();
        test_three();
        test_wrap();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
